// File: rtl/memory_arbiter.sv
// Two-master arbiter for the Hack data-memory port: one 3-cycle transaction per grant,
// round-robin or CPU-priority with a bounded burst so the loader is never starved.
module memory_arbiter #(
  parameter bit          CPU_PRIORITY = 1'b0,
  parameter int          MAX_BURST    = 4,
  parameter logic [15:0] MAX_ADDR     = 16'h200F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [15:0] addr_a,
  input  logic [15:0] wdata_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [15:0] addr_b,
  input  logic [15:0] wdata_b,
  output logic        ack_b,
  output logic [15:0] rdata,
  output logic        err,
  output logic [1:0]  owner,
  output logic [15:0] mem_address,
  output logic        mem_load,
  output logic [15:0] mem_in,
  input  logic [15:0] mem_out
);

  localparam int            BW          = $clog2(MAX_BURST + 2);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_reg;
  logic          last_b_reg;
  logic [BW-1:0] burst_cnt_reg;
  logic          lat_we_reg;
  logic [15:0]   lat_addr_reg;

  logic          grant_b;
  logic          win_we;
  logic [15:0]   win_addr;
  logic [15:0]   win_wdata;
  logic          lat_bad;

  // Winner of the current ARB cycle; only meaningful when some request is pending.
  always_comb begin
    grant_b = req_b;
    if (req_a && req_b) begin
      if (CPU_PRIORITY) grant_b = (burst_cnt_reg >= BURST_LIMIT);
      else              grant_b = ~last_b_reg;
    end
    win_we    = grant_b ? we_b    : we_a;
    win_addr  = grant_b ? addr_b  : addr_a;
    win_wdata = grant_b ? wdata_b : wdata_a;
  end

  assign lat_bad = (lat_addr_reg > MAX_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ARB;
      last_b_reg    <= 1'b1;
      burst_cnt_reg <= '0;
      lat_we_reg    <= 1'b0;
      lat_addr_reg  <= '0;
      ack_a         <= 1'b0;
      ack_b         <= 1'b0;
      rdata         <= '0;
      err           <= 1'b0;
      owner         <= 2'b00;
      mem_address   <= '0;
      mem_load      <= 1'b0;
      mem_in        <= '0;
    end else begin
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      mem_load <= 1'b0;
      // The burst only counts A wins against a B that is actually waiting.
      if (!req_b) burst_cnt_reg <= '0;

      case (state_reg)
        ARB: begin
          if (req_a || req_b) begin
            lat_we_reg   <= win_we;
            lat_addr_reg <= win_addr;
            mem_address  <= win_addr;
            mem_in       <= win_wdata;
            mem_load     <= win_we && (win_addr <= MAX_ADDR);
            owner        <= grant_b ? 2'b10 : 2'b01;
            last_b_reg   <= grant_b;
            if (grant_b)    burst_cnt_reg <= '0;
            else if (req_b) burst_cnt_reg <= burst_cnt_reg + 1'b1;
            state_reg    <= ACCESS;
          end
        end
        ACCESS: begin
          state_reg <= RESP;
        end
        RESP: begin
          ack_a     <= (owner == 2'b01);
          ack_b     <= (owner == 2'b10);
          err       <= lat_bad;
          rdata     <= (!lat_we_reg && !lat_bad) ? mem_out : 16'h0000;
          owner     <= 2'b00;
          state_reg <= ARB;
        end
        default: begin
          state_reg <= ARB;
        end
      endcase
    end
  end

endmodule
